// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: register-file encodings, latency classes and the
// NOP encoding used when the decode stage injects a bubble into execute.
package rv_pipe_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic {
        FILE_GPR = 1'b0,
        FILE_FPR = 1'b1
    } reg_file_e;

    // A latency of zero marks a producer whose completion arrives on the writeback port.
    localparam int LAT_VAR = 0;

    localparam logic [31:0] NOP_INSN = 32'h00000013;

    localparam int LAT_ALU = 1;
    localparam int LAT_MUL = 3;
    localparam int LAT_FPU = 4;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: tracks whether a register has an outstanding write and,
// for fixed-latency producers, how many cycles remain until it lands.
module sb_entry
    import rv_pipe_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_accept,
    input  logic [CNT_W-1:0] i_lat,
    input  logic             i_wbMatch,
    output logic             o_busy,
    output logic             o_var,
    output logic             o_clearing,
    output logic             o_busyNext
);

    logic             r_busy;
    logic             r_var;
    logic [CNT_W-1:0] r_cnt;

    logic             w_clearing;
    logic             w_busyNext;
    logic             w_varNext;
    logic [CNT_W-1:0] w_cntNext;

    assign w_clearing = r_busy & (r_var ? i_wbMatch : (r_cnt == CNT_W'(1)));

    // A new accept outranks a same-cycle clear so a bypassed re-issue re-arms the slot.
    always_comb begin
        w_busyNext = r_busy;
        w_varNext  = r_var;
        w_cntNext  = r_cnt;
        if (i_accept) begin
            w_busyNext = 1'b1;
            w_varNext  = (i_lat == CNT_W'(LAT_VAR));
            w_cntNext  = i_lat;
        end else if (w_clearing) begin
            w_busyNext = 1'b0;
            w_varNext  = 1'b0;
            w_cntNext  = '0;
        end else if (r_busy && !r_var) begin
            w_cntNext  = r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 1'b0;
            r_var  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busyNext;
            r_var  <= w_varNext;
            r_cnt  <= w_cntNext;
        end
    end

    assign o_busy     = r_busy;
    assign o_var      = r_var;
    assign o_clearing = w_clearing;
    assign o_busyNext = w_busyNext;

endmodule

// File: rtl/pipeline_scoreboard.sv
// Per-register pending-write scoreboard beside decode: raises the issue stall on
// RAW/WAW hazards against GPR/FPR writes still in flight.
module pipeline_scoreboard
    import rv_pipe_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int CNT_W     = 4,
    parameter int WB_BYPASS = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              issue_valid,
    input  logic [$clog2(NUM_REGS)-1:0]       issue_rs1,
    input  logic                              issue_rs1_en,
    input  logic                              issue_rs1_fpr,
    input  logic [$clog2(NUM_REGS)-1:0]       issue_rs2,
    input  logic                              issue_rs2_en,
    input  logic                              issue_rs2_fpr,
    input  logic [$clog2(NUM_REGS)-1:0]       issue_rd,
    input  logic                              issue_rd_wr,
    input  logic                              issue_rd_fpr,
    input  logic [CNT_W-1:0]                  issue_lat,
    input  logic                              flush,
    input  logic                              wb_valid,
    input  logic [$clog2(NUM_REGS)-1:0]       wb_rd,
    input  logic                              wb_fpr,
    output logic                              stall,
    output logic [NUM_REGS-1:0]               busy_gpr,
    output logic [NUM_REGS-1:0]               busy_fpr,
    output logic [$clog2(2*NUM_REGS):0]       pending,
    output logic                              wb_err
);

    localparam int IDX_W   = $clog2(NUM_REGS);
    localparam int SLOT_W  = IDX_W + 1;
    localparam int SLOTS   = 2 * NUM_REGS;
    localparam int PEND_W  = $clog2(2 * NUM_REGS) + 1;
    localparam bit BYPASS  = (WB_BYPASS != 0);

    // Slot index is {file, reg}, so the FPR file occupies the upper half of each vector.
    logic [SLOT_W-1:0] w_rs1Slot;
    logic [SLOT_W-1:0] w_rs2Slot;
    logic [SLOT_W-1:0] w_rdSlot;
    logic [SLOT_W-1:0] w_wbSlot;

    logic [SLOTS-1:0]  w_busy;
    logic [SLOTS-1:0]  w_var;
    logic [SLOTS-1:0]  w_clearing;
    logic [SLOTS-1:0]  w_busyNext;

    logic              w_rs1X0;
    logic              w_rs2X0;
    logic              w_rdX0;
    logic              w_hazRs1;
    logic              w_hazRs2;
    logic              w_hazRd;
    logic              w_stall;
    logic              w_accept;
    logic              w_wbBad;
    logic [PEND_W-1:0] w_popNext;

    logic [PEND_W-1:0] r_pending;
    logic              r_wbErr;

    assign w_rs1Slot = {issue_rs1_fpr, issue_rs1};
    assign w_rs2Slot = {issue_rs2_fpr, issue_rs2};
    assign w_rdSlot  = {issue_rd_fpr, issue_rd};
    assign w_wbSlot  = {wb_fpr, wb_rd};

    assign w_rs1X0 = (issue_rs1_fpr == logic'(FILE_GPR)) && (issue_rs1 == '0);
    assign w_rs2X0 = (issue_rs2_fpr == logic'(FILE_GPR)) && (issue_rs2 == '0);
    assign w_rdX0  = (issue_rd_fpr  == logic'(FILE_GPR)) && (issue_rd  == '0);

    assign w_hazRs1 = issue_rs1_en && !w_rs1X0 && w_busy[w_rs1Slot]
                      && !(BYPASS && w_clearing[w_rs1Slot]);
    assign w_hazRs2 = issue_rs2_en && !w_rs2X0 && w_busy[w_rs2Slot]
                      && !(BYPASS && w_clearing[w_rs2Slot]);
    assign w_hazRd  = issue_rd_wr && !w_rdX0 && w_busy[w_rdSlot]
                      && !(BYPASS && w_clearing[w_rdSlot]);

    assign w_stall  = issue_valid && !flush && (w_hazRs1 || w_hazRs2 || w_hazRd);
    assign w_accept = issue_valid && !flush && !w_stall && issue_rd_wr && !w_rdX0;

    for (genvar s = 0; s < SLOTS; s++) begin : gSlot
        localparam logic [SLOT_W-1:0] SLOT = SLOT_W'(s);

        sb_entry #(
            .CNT_W (CNT_W)
        ) uEntry (
            .clk        (clk),
            .rst        (rst),
            .i_accept   (w_accept && (w_rdSlot == SLOT)),
            .i_lat      (issue_lat),
            .i_wbMatch  (wb_valid && (w_wbSlot == SLOT)),
            .o_busy     (w_busy[s]),
            .o_var      (w_var[s]),
            .o_clearing (w_clearing[s]),
            .o_busyNext (w_busyNext[s])
        );
    end

    // A completion is only legitimate for a slot waiting on a variable-latency producer.
    assign w_wbBad = wb_valid && !(w_busy[w_wbSlot] && w_var[w_wbSlot]);

    always_comb begin
        w_popNext = '0;
        for (int i = 0; i < SLOTS; i++) begin
            w_popNext = w_popNext + PEND_W'(w_busyNext[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
            r_wbErr   <= 1'b0;
        end else begin
            r_pending <= w_popNext;
            r_wbErr   <= r_wbErr || w_wbBad;
        end
    end

    assign stall    = w_stall;
    assign busy_gpr = w_busy[NUM_REGS-1:0];
    assign busy_fpr = w_busy[SLOTS-1:NUM_REGS];
    assign pending  = r_pending;
    assign wb_err   = r_wbErr;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Bench for pipeline_scoreboard: directed hazard scenarios followed by random
// traffic, all compared against a remaining-cycles model of every register.
module tb_pipeline_scoreboard;

    localparam int NREGS  = 32;
    localparam int CNT_W  = 4;
    localparam bit BYPASS = 1'b1;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic       rs1En;
        logic       rs1F;
        logic [4:0] rs2;
        logic       rs2En;
        logic       rs2F;
        logic [4:0] rd;
        logic       rdWr;
        logic       rdF;
        logic [3:0] lat;
        logic       fl;
        logic       wbV;
        logic [4:0] wbR;
        logic       wbF;
    } stim_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             issue_valid = 1'b0;
    logic [4:0]       issue_rs1 = '0;
    logic             issue_rs1_en = 1'b0;
    logic             issue_rs1_fpr = 1'b0;
    logic [4:0]       issue_rs2 = '0;
    logic             issue_rs2_en = 1'b0;
    logic             issue_rs2_fpr = 1'b0;
    logic [4:0]       issue_rd = '0;
    logic             issue_rd_wr = 1'b0;
    logic             issue_rd_fpr = 1'b0;
    logic [CNT_W-1:0] issue_lat = '0;
    logic             flush = 1'b0;
    logic             wb_valid = 1'b0;
    logic [4:0]       wb_rd = '0;
    logic             wb_fpr = 1'b0;
    logic             stall;
    logic [NREGS-1:0] busy_gpr;
    logic [NREGS-1:0] busy_fpr;
    logic [6:0]       pending;
    logic             wb_err;

    always #5 clk = ~clk;

    pipeline_scoreboard #(
        .NUM_REGS  (NREGS),
        .CNT_W     (CNT_W),
        .WB_BYPASS (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs1_en  (issue_rs1_en),
        .issue_rs1_fpr (issue_rs1_fpr),
        .issue_rs2     (issue_rs2),
        .issue_rs2_en  (issue_rs2_en),
        .issue_rs2_fpr (issue_rs2_fpr),
        .issue_rd      (issue_rd),
        .issue_rd_wr   (issue_rd_wr),
        .issue_rd_fpr  (issue_rd_fpr),
        .issue_lat     (issue_lat),
        .flush         (flush),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_fpr        (wb_fpr),
        .stall         (stall),
        .busy_gpr      (busy_gpr),
        .busy_fpr      (busy_fpr),
        .pending       (pending),
        .wb_err        (wb_err)
    );

    int checkCount = 0;
    int passCount  = 0;

    // Model: cycles left before each register's write lands; 0 = idle, -1 = waiting on writeback.
    int rem [2][NREGS];
    bit mWbErr;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    function automatic void modelReset();
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < NREGS; r++) rem[f][r] = 0;
        mWbErr = 1'b0;
    endfunction

    function automatic bit mClearing(int f, int r, stim_t s);
        return (rem[f][r] == 1) ||
               (rem[f][r] == -1 && s.wbV && int'(s.wbF) == f && int'(s.wbR) == r);
    endfunction

    function automatic bit mHaz(logic en, logic fl, logic [4:0] idx, stim_t s);
        int f = int'(fl);
        int r = int'(idx);
        if (!en || rem[f][r] == 0) return 1'b0;
        if (BYPASS && mClearing(f, r, s)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic stim_t idleStim();
        stim_t z = '{default: '0};
        return z;
    endfunction

    // Drives one decode cycle, checks outputs against the model, then advances the model.
    task automatic applyStimulus(input stim_t s, output logic obsStall);
        logic [NREGS-1:0] expG;
        logic [NREGS-1:0] expF;
        int  expPend;
        bit  expStall;
        bit  expAccept;
        int  nxt [2][NREGS];
        @(negedge clk);
        issue_valid   = s.v;
        issue_rs1     = s.rs1;
        issue_rs1_en  = s.rs1En;
        issue_rs1_fpr = s.rs1F;
        issue_rs2     = s.rs2;
        issue_rs2_en  = s.rs2En;
        issue_rs2_fpr = s.rs2F;
        issue_rd      = s.rd;
        issue_rd_wr   = s.rdWr;
        issue_rd_fpr  = s.rdF;
        issue_lat     = s.lat;
        flush         = s.fl;
        wb_valid      = s.wbV;
        wb_rd         = s.wbR;
        wb_fpr        = s.wbF;
        #1;
        expStall  = s.v && !s.fl && (mHaz(s.rs1En, s.rs1F, s.rs1, s) ||
                                     mHaz(s.rs2En, s.rs2F, s.rs2, s) ||
                                     mHaz(s.rdWr, s.rdF, s.rd, s));
        expAccept = s.v && !s.fl && !expStall && s.rdWr && !(s.rdF == 1'b0 && s.rd == 5'd0);
        expPend = 0;
        for (int r = 0; r < NREGS; r++) begin
            expG[r] = (rem[0][r] != 0);
            expF[r] = (rem[1][r] != 0);
            expPend += int'(expG[r]) + int'(expF[r]);
        end
        checkOutput("stall", stall, expStall);
        checkOutput("busy_gpr", busy_gpr, expG);
        checkOutput("busy_fpr", busy_fpr, expF);
        checkOutput("pending", pending, expPend);
        checkOutput("wb_err", wb_err, mWbErr);
        obsStall = stall;
        @(posedge clk);
        if (s.wbV && rem[int'(s.wbF)][int'(s.wbR)] != -1) mWbErr = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < NREGS; r++) begin
                if (expAccept && f == int'(s.rdF) && r == int'(s.rd))
                    nxt[f][r] = (s.lat == 0) ? -1 : int'(s.lat);
                else if (mClearing(f, r, s))
                    nxt[f][r] = 0;
                else if (rem[f][r] > 1)
                    nxt[f][r] = rem[f][r] - 1;
                else
                    nxt[f][r] = rem[f][r];
            end
        end
        rem = nxt;
    endtask

    initial begin
        stim_t s;
        logic  obs;
        modelReset();

        #3;
        checkOutput("rstStall", stall, 1'b0);
        checkOutput("rstBusyGpr", busy_gpr, '0);
        checkOutput("rstBusyFpr", busy_fpr, '0);
        checkOutput("rstPending", pending, '0);
        checkOutput("rstWbErr", wb_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // x5 with latency 3 stays busy for exactly three cycles
        s = idleStim(); s.v = 1; s.rd = 5; s.rdWr = 1; s.lat = 3;
        applyStimulus(s, obs);
        checkOutput("x5IssueStall", obs, 1'b0);
        #1 checkOutput("x5BusyAfterAccept", busy_gpr[5], 1'b1);
        checkOutput("x5PendingOne", pending, 7'd1);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(idleStim(), obs);
            #1 checkOutput($sformatf("x5BusyCycle%0d", k), busy_gpr[5], (k < 3));
        end
        checkOutput("x5PendingZero", pending, 7'd0);

        // RAW on x5: two stalled cycles, then the bypass lets it through
        s = idleStim(); s.v = 1; s.rd = 5; s.rdWr = 1; s.lat = 3;
        applyStimulus(s, obs);
        s = idleStim(); s.v = 1; s.rs1 = 5; s.rs1En = 1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(s, obs);
            checkOutput($sformatf("rawStall%0d", k), obs, (k < 2));
        end

        // x0 is never tracked, and f0 is separate from x0
        s = idleStim(); s.v = 1; s.rd = 0; s.rdWr = 1; s.lat = 4;
        applyStimulus(s, obs);
        s = idleStim(); s.v = 1; s.rs1 = 0; s.rs1En = 1;
        applyStimulus(s, obs);
        checkOutput("x0ReadStall", obs, 1'b0);
        #1 checkOutput("x0NotBusy", busy_gpr, '0);
        s = idleStim(); s.v = 1; s.rd = 0; s.rdF = 1; s.rdWr = 1; s.lat = 4;
        applyStimulus(s, obs);
        s = idleStim(); s.v = 1; s.rs1 = 0; s.rs1En = 1;
        applyStimulus(s, obs);
        checkOutput("x0VsF0Stall", obs, 1'b0);
        s = idleStim(); s.v = 1; s.rs2 = 0; s.rs2En = 1; s.rs2F = 1;
        applyStimulus(s, obs);
        checkOutput("f0ReadStall", obs, 1'b1);
        for (int k = 0; k < 5; k++) applyStimulus(idleStim(), obs);

        // Variable latency on x7, completed by writeback with a same-cycle dependent issue
        s = idleStim(); s.v = 1; s.rd = 7; s.rdWr = 1; s.lat = 0;
        applyStimulus(s, obs);
        for (int k = 0; k < 4; k++) applyStimulus(idleStim(), obs);
        #1 checkOutput("x7StillBusy", busy_gpr[7], 1'b1);
        s = idleStim(); s.v = 1; s.rs1 = 7; s.rs1En = 1; s.rd = 8; s.rdWr = 1; s.lat = 1;
        s.wbV = 1; s.wbR = 7;
        applyStimulus(s, obs);
        checkOutput("x7BypassStall", obs, 1'b0);
        #1 checkOutput("x7Cleared", busy_gpr[7], 1'b0);
        checkOutput("x8Accepted", busy_gpr[8], 1'b1);
        checkOutput("wbErrClean", wb_err, 1'b0);
        s = idleStim(); s.wbV = 1; s.wbR = 7;
        applyStimulus(s, obs);
        #1 checkOutput("wbErrSticky", wb_err, 1'b1);

        // Flushed issue never marks its destination
        s = idleStim(); s.v = 1; s.rd = 9; s.rdWr = 1; s.lat = 2; s.fl = 1;
        applyStimulus(s, obs);
        checkOutput("flushStall", obs, 1'b0);
        #1 checkOutput("flushX9Idle", busy_gpr[9], 1'b0);

        // WAW on x3, then asynchronous reset in the middle of the countdown
        s = idleStim(); s.v = 1; s.rd = 3; s.rdWr = 1; s.lat = 5;
        applyStimulus(s, obs);
        s = idleStim(); s.v = 1; s.rd = 3; s.rdWr = 1; s.lat = 1;
        applyStimulus(s, obs);
        checkOutput("wawStall0", obs, 1'b1);
        applyStimulus(s, obs);
        checkOutput("wawStall1", obs, 1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("asyncStall", stall, 1'b0);
        checkOutput("asyncBusyGpr", busy_gpr, '0);
        checkOutput("asyncBusyFpr", busy_fpr, '0);
        checkOutput("asyncPending", pending, '0);
        checkOutput("asyncWbErr", wb_err, 1'b0);
        modelReset();
        @(negedge clk);
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
        flush       = 1'b0;
        rst         = 1'b1;

        // Random traffic over a small register window to keep hazards frequent
        for (int n = 0; n < 600; n++) begin
            s = idleStim();
            s.v     = ($urandom_range(0, 3) != 0);
            s.rs1   = 5'($urandom_range(0, 7));
            s.rs1En = 1'($urandom_range(0, 1));
            s.rs1F  = 1'($urandom_range(0, 1));
            s.rs2   = 5'($urandom_range(0, 7));
            s.rs2En = 1'($urandom_range(0, 1));
            s.rs2F  = 1'($urandom_range(0, 1));
            s.rd    = 5'($urandom_range(0, 7));
            s.rdWr  = ($urandom_range(0, 3) != 0);
            s.rdF   = 1'($urandom_range(0, 1));
            s.lat   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
            s.fl    = ($urandom_range(0, 7) == 0);
            s.wbV   = ($urandom_range(0, 2) == 0);
            s.wbR   = 5'($urandom_range(0, 7));
            s.wbF   = 1'($urandom_range(0, 1));
            for (int t = 0; t < 8; t++) begin
                int f = $urandom_range(0, 1);
                int r = $urandom_range(0, 7);
                if (rem[f][r] == -1 && $urandom_range(0, 7) != 0) begin
                    s.wbF = 1'(f);
                    s.wbR = 5'(r);
                    break;
                end
            end
            applyStimulus(s, obs);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pipeline_scoreboard.md
Name: pipeline_scoreboard

Overview:
- Per-register pending-write scoreboard for the RV32IMF pipeline. It replaces the fixed three-stage rd-compare hazard logic.
- Tracks outstanding writes to the GPR and FPR files, including fixed-latency (ALU/MUL/FPU) and variable-latency (load, divide) producers.
- Generates the decode-stage issue stall for RAW and WAW hazards.
- Sits beside decode: issue from D, completion from writeback.

Parameters:
- NUM_REGS, 32, registers per file; power of two.
- CNT_W, 4, latency counter width; max fixed latency 2^CNT_W-1.
- WB_BYPASS, 1, when 1 a register being cleared this cycle does not cause a hazard.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- issue_valid  in  1  instruction in D requests issue
- issue_rs1  in  log2(NUM_REGS)  source 1 index
- issue_rs1_en  in  1  source 1 is read
- issue_rs1_fpr  in  1  source 1 is in the FPR file
- issue_rs2  in  log2(NUM_REGS)  source 2 index
- issue_rs2_en  in  1  source 2 is read
- issue_rs2_fpr  in  1  source 2 is in the FPR file
- issue_rd  in  log2(NUM_REGS)  destination index
- issue_rd_wr  in  1  instruction writes rd
- issue_rd_fpr  in  1  destination is in the FPR file
- issue_lat  in  CNT_W  cycles until writeback; 0 = variable latency
- flush  in  1  branch/jump redirect from E; kills the D instruction
- wb_valid  in  1  variable-latency completion
- wb_rd  in  log2(NUM_REGS)  completing register
- wb_fpr  in  1  completing register is in the FPR file
- stall  out  1  hold F/D and inject a NOP into E
- busy_gpr  out  NUM_REGS  pending-write vector, GPR file
- busy_fpr  out  NUM_REGS  pending-write vector, FPR file
- pending  out  log2(2*NUM_REGS)+1  count of busy entries
- wb_err  out  1  sticky: wb_valid seen for a non-busy or fixed-latency entry

Behaviour:
- Reset (rst low, asynchronous): all busy, count and var bits cleared. stall=0, busy_*=0, pending=0, wb_err=0.
- Per entry (file f, index r): busy bit, var bit, CNT_W countdown.
- GPR x0 is never marked busy and never causes a hazard. FPR f0 is tracked normally.
- hazard_src(s):
  - requires s_en and busy[file][s];
  - when WB_BYPASS=1, excluded if the entry is clearing this cycle.
- hazard_rd (WAW): requires issue_rd_wr and busy[file][rd], with the same bypass exclusion.
- stall = issue_valid & ~flush & (hazard_rs1 | hazard_rs2 | hazard_rd). Combinational, no added latency.
- accept = issue_valid & ~flush & ~stall & issue_rd_wr & ~(gpr & rd==0).
- On accept, at the next edge: busy=1.
  - If issue_lat != 0: var=0, cnt=issue_lat.
  - If issue_lat == 0: var=1.
- Countdown: each cycle, every busy non-var entry decrements cnt.
  - The entry is clearing when cnt==1; busy drops at that edge.
  - Consequence: lat=N keeps the register busy for exactly N cycles after the accept edge.
- Variable latency: a var entry is clearing when wb_valid matches its file and index; busy and var drop at that edge.
- wb_valid matching a non-busy or non-var entry: no state change; wb_err set until reset.
- Same cycle, same entry, clear and accept (bypass case): the accept wins; the entry is re-armed with the new latency.
- Flush: only blocks the D-stage accept. Entries already accepted are older than the redirect and always complete, so they are not cleared.
- pending: registered popcount of all busy bits, updated the same edge as the busy bits.
- Reset mid-operation: all entries drop immediately, without waiting for the clock edge.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - REG_IDX_W and the FILE_GPR/FILE_FPR encodings;
  - LAT_VAR=0;
  - the NOP encoding 32'h00000013;
  - default latencies LAT_ALU=1, LAT_MUL=3, LAT_FPU=4.
- Sub-module sb_entry: one busy/var/cnt slot with accept, wb-match and clearing outputs. It is instantiated 2*NUM_REGS times via generate.
- The top level holds the hazard compare, the popcount and wb_err.

Test Plan:
- Reset check: deassert rst, then issue rd=x5, lat=3. Required: busy_gpr[5]=1 for exactly 3 cycles, pending 1 then 0.
- RAW stall: issue rd=x5, lat=3, then next cycle rs1=x5. Required: stall=1 for 2 cycles (WB_BYPASS=1), then the issue is accepted.
- x0 and FPR separation: issue rd=x0, lat=4, then rs1=x0. Required: no stall, busy_gpr=0. Issue rd=f0 (FPR), lat=4, then rs1=x0 GPR. Required: no stall. Then rs2=f0 with rs2_fpr=1. Required: stall.
- Variable latency: issue rd=x7, lat=0. Required: busy_gpr[7]=1 indefinitely. wb_valid with wb_rd=7, then a dependent issue. Required: the dependent issue is accepted the same cycle when WB_BYPASS=1. A second wb for x7 sets wb_err=1.
- Flush: issue_valid with rd=x9 together with flush=1. Required: busy_gpr[9] stays 0, stall=0.
- WAW and async reset: issue rd=x3, lat=5, then rd=x3, lat=1. Required: stall until the first write clears. Assert rst mid-count. Required: all outputs 0 without waiting for a clock edge.
